// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
//==============================================================================
// Module   : fft_stage_sequencer_if
// Brief    : Command and address bus between an FFT controller and the
//            stage sequencer (butterfly read, twiddle index, output phase).
// Revision : 1.0 - initial release
//==============================================================================
interface fft_stage_sequencer_if #(
    parameter int SIZE = 4
);
    logic            start;
    logic            abort;
    logic            ifft;
    logic            en_out;
    logic [SIZE-1:0] rd_ptr;
    logic [SIZE-1:0] rd_ptr_b;
    logic [10:0]     rd_ptr_angle;
    logic [3:0]      stage;
    logic            en_rd;
    logic [SIZE-1:0] out_ptr;
    logic            out_valid;
    logic            finish_FFT;
    logic            done_o;
    logic            busy;

    modport master (
        output start, abort, ifft, en_out,
        input  rd_ptr, rd_ptr_b, rd_ptr_angle, stage, en_rd,
        input  out_ptr, out_valid, finish_FFT, done_o, busy
    );

    modport slave (
        input  start, abort, ifft, en_out,
        output rd_ptr, rd_ptr_b, rd_ptr_angle, stage, en_rd,
        output out_ptr, out_valid, finish_FFT, done_o, busy
    );
endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : fft_stage_sequencer
// Brief    : Radix-2 DIT stage sequencer: butterfly operand addresses and
//            twiddle indices per stage, then a paced (bit-reversed) readout.
// Revision : 1.0 - initial release
//==============================================================================
module fft_stage_sequencer #(
    parameter int SIZE       = 4,
    parameter int PIPE_GAP   = 2,
    parameter int OUT_GAP    = 0,
    parameter int BITREV_OUT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_stage_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPUTE = 3'd1,
        S_GAP     = 3'd2,
        S_FINISH  = 3'd3,
        S_OUTPUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int              c_KW         = SIZE - 1;
    localparam int              c_MW         = SIZE + 1;
    localparam logic [SIZE:0]   c_N_WORDS    = {1'b1, {SIZE{1'b0}}};
    localparam logic [3:0]      c_LAST_STAGE = 4'(SIZE);
    localparam logic [3:0]      c_GAP_LOAD   = 4'(PIPE_GAP - 1);
    localparam logic [15:0]     c_OUT_GAP    = 16'(OUT_GAP);

    // span-1 for a stage: selects the butterfly index j inside its group
    function automatic logic [SIZE-1:0] f_mask(input logic [3:0] s);
        return (SIZE'(1) << (s - 4'd1)) - SIZE'(1);
    endfunction

    function automatic logic [SIZE-1:0] f_top(input logic [SIZE-2:0] k, input logic [3:0] s);
        logic [SIZE-1:0] kk;
        logic [SIZE-1:0] msk;
        kk  = {1'b0, k};
        msk = f_mask(s);
        return ((kk & ~msk) << 1) | (kk & msk);
    endfunction

    function automatic logic [SIZE-1:0] f_bot(input logic [SIZE-2:0] k, input logic [3:0] s);
        return f_top(k, s) | (SIZE'(1) << (s - 4'd1));
    endfunction

    function automatic logic [10:0] f_angle(input logic [SIZE-2:0] k, input logic [3:0] s,
                                            input logic inv);
        logic [10:0] a;
        a = 11'({1'b0, k} & f_mask(s)) << (4'd11 - s);
        return inv ? (11'd0 - a) : a;
    endfunction

    function automatic logic [SIZE-1:0] f_bitrev(input logic [SIZE-1:0] m);
        logic [SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i] = m[SIZE-1-i];
        return r;
    endfunction

    state_t          r_state;
    logic [3:0]      r_stage;
    logic [SIZE-2:0] r_k;
    logic [3:0]      r_gap;
    logic [SIZE:0]   r_m;
    logic [15:0]     r_ogap;
    logic            r_ifft;

    logic [SIZE-1:0] r_rd_ptr;
    logic [SIZE-1:0] r_rd_ptr_b;
    logic [10:0]     r_angle;
    logic [3:0]      r_stage_o;
    logic            r_en_rd;
    logic [SIZE-1:0] r_out_ptr;
    logic            r_out_valid;
    logic            r_finish;
    logic            r_done;
    logic            r_busy;

    logic            w_last_k;
    logic            w_advance;
    logic [SIZE-2:0] w_k_next;
    logic [3:0]      w_stage_next;

    assign w_last_k     = (r_k == '1);
    assign w_k_next     = r_k + c_KW'(1);
    assign w_stage_next = r_stage + 4'd1;
    // end of a stage: either straight out of COMPUTE or after the drain gap
    assign w_advance    = ((r_state == S_COMPUTE) && w_last_k && (PIPE_GAP == 0)) ||
                          ((r_state == S_GAP) && (r_gap == 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_stage     <= 4'd0;
            r_k         <= '0;
            r_gap       <= 4'd0;
            r_m         <= '0;
            r_ogap      <= 16'd0;
            r_ifft      <= 1'b0;
            r_rd_ptr    <= '0;
            r_rd_ptr_b  <= '0;
            r_angle     <= 11'd0;
            r_stage_o   <= 4'd0;
            r_en_rd     <= 1'b0;
            r_out_ptr   <= '0;
            r_out_valid <= 1'b0;
            r_finish    <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_en_rd     <= 1'b0;
            r_out_valid <= 1'b0;
            r_finish    <= 1'b0;
            r_done      <= 1'b0;
            r_stage_o   <= 4'd0;
            if (r_ogap != 16'd0) r_ogap <= r_ogap - 16'd1;

            if (bus.abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_stage <= 4'd0;
                r_k     <= '0;
                r_gap   <= 4'd0;
                r_m     <= '0;
                r_ogap  <= 16'd0;
            end else if (w_advance) begin
                if (r_stage == c_LAST_STAGE) begin
                    r_state  <= S_FINISH;
                    r_finish <= 1'b1;
                end else begin
                    r_state    <= S_COMPUTE;
                    r_stage    <= w_stage_next;
                    r_k        <= '0;
                    r_en_rd    <= 1'b1;
                    r_stage_o  <= w_stage_next;
                    r_rd_ptr   <= f_top('0, w_stage_next);
                    r_rd_ptr_b <= f_bot('0, w_stage_next);
                    r_angle    <= f_angle('0, w_stage_next, r_ifft);
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state    <= S_COMPUTE;
                            r_busy     <= 1'b1;
                            r_stage    <= 4'd1;
                            r_k        <= '0;
                            r_ifft     <= bus.ifft;
                            r_en_rd    <= 1'b1;
                            r_stage_o  <= 4'd1;
                            r_rd_ptr   <= f_top('0, 4'd1);
                            r_rd_ptr_b <= f_bot('0, 4'd1);
                            r_angle    <= f_angle('0, 4'd1, bus.ifft);
                        end
                    end
                    S_COMPUTE: begin
                        if (w_last_k) begin
                            r_state <= S_GAP;
                            r_gap   <= c_GAP_LOAD;
                        end else begin
                            r_k        <= w_k_next;
                            r_en_rd    <= 1'b1;
                            r_stage_o  <= r_stage;
                            r_rd_ptr   <= f_top(w_k_next, r_stage);
                            r_rd_ptr_b <= f_bot(w_k_next, r_stage);
                            r_angle    <= f_angle(w_k_next, r_stage, r_ifft);
                        end
                    end
                    S_GAP: begin
                        r_gap <= r_gap - 4'd1;
                    end
                    S_FINISH: begin
                        r_state <= S_OUTPUT;
                        r_m     <= '0;
                        r_ogap  <= 16'd0;
                    end
                    S_OUTPUT: begin
                        // r_m reaching N means the last word already went out
                        if (r_m == c_N_WORDS) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (bus.en_out && (r_ogap == 16'd0)) begin
                            r_out_valid <= 1'b1;
                            r_out_ptr   <= (BITREV_OUT != 0) ? f_bitrev(r_m[SIZE-1:0])
                                                             : r_m[SIZE-1:0];
                            r_m         <= r_m + c_MW'(1);
                            r_ogap      <= c_OUT_GAP;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rd_ptr       = r_rd_ptr;
    assign bus.rd_ptr_b     = r_rd_ptr_b;
    assign bus.rd_ptr_angle = r_angle;
    assign bus.stage        = r_stage_o;
    assign bus.en_rd        = r_en_rd;
    assign bus.out_ptr      = r_out_ptr;
    assign bus.out_valid    = r_out_valid;
    assign bus.finish_FFT   = r_finish;
    assign bus.done_o       = r_done;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_fft_stage_sequencer
// Brief    : Scoreboard bench for fft_stage_sequencer (SIZE=3, two OUT_GAP cfgs).
// Revision : 1.0 - initial release
//==============================================================================
module tb_fft_stage_sequencer;
    localparam int SZ = 3;
    localparam int NW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.SIZE(SZ)) if0 ();
    fft_stage_sequencer_if #(.SIZE(SZ)) if1 ();

    fft_stage_sequencer #(.SIZE(SZ), .PIPE_GAP(2), .OUT_GAP(0), .BITREV_OUT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    fft_stage_sequencer #(.SIZE(SZ), .PIPE_GAP(2), .OUT_GAP(3), .BITREV_OUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int total = 0;
    int bad   = 0;
    int exp_rd[$];
    int exp_rdb[$];
    int exp_ang[$];
    int exp_stg[$];
    int exp_out[$];

    task automatic push_compute(input bit inv);
        for (int s = 1; s <= SZ; s++) begin
            for (int k = 0; k < NW/2; k++) begin
                int span, j, top, a;
                span = 1 << (s - 1);
                j    = k % span;
                top  = (k / span) * 2 * span + j;
                a    = j * (2048 >> s);
                if (inv) a = (2048 - a) % 2048;
                exp_rd.push_back(top);
                exp_rdb.push_back(top + span);
                exp_ang.push_back(a);
                exp_stg.push_back(s);
            end
        end
    endtask

    task automatic push_output();
        for (int m = 0; m < NW; m++) begin
            int r;
            r = 0;
            for (int b = 0; b < SZ; b++) if (((m >> b) & 1) == 1) r = r | (1 << (SZ - 1 - b));
            exp_out.push_back(r);
        end
    endtask

    task automatic test_reset();
        logic [28:0] v0, v1;
        #1 rst_n = 1'b0;
        #1;
        v0 = {if0.rd_ptr, if0.rd_ptr_b, if0.rd_ptr_angle, if0.stage, if0.en_rd, if0.out_ptr,
              if0.out_valid, if0.finish_FFT, if0.done_o, if0.busy};
        v1 = {if1.rd_ptr, if1.rd_ptr_b, if1.rd_ptr_angle, if1.stage, if1.en_rd, if1.out_ptr,
              if1.out_valid, if1.finish_FFT, if1.done_o, if1.busy};
        total++; if (v0 !== 29'd0) begin bad++; $display("FAIL reset_outputs0: got %h want 0", v0); end
        total++; if (v1 !== 29'd0) begin bad++; $display("FAIL reset_outputs1: got %h want 0", v1); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", if0.busy); end
    endtask

    task automatic test_compute(input bit inv);
        int first_rd, last_out, nfin, ndone;
        bit seen_done, finished;
        logic [20:0] act, expv;
        exp_rd.delete(); exp_rdb.delete(); exp_ang.delete(); exp_stg.delete(); exp_out.delete();
        push_compute(inv);
        push_output();
        first_rd = -1; last_out = -1; nfin = 0; ndone = 0; seen_done = 0; finished = 0;
        @(negedge clk); if0.start = 1'b1; if0.ifft = inv; if0.en_out = 1'b1;
        @(negedge clk); if0.start = 1'b0; if0.ifft = ~inv;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (seen_done) begin
                total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL busy_after_done: got %b want 0", if0.busy); end
                finished = 1;
                break;
            end
            if (if0.en_rd === 1'b1) begin
                if (first_rd < 0) first_rd = cyc;
                total++;
                if (exp_rd.size() == 0) begin
                    bad++; $display("FAIL extra_en_rd: got en_rd at cycle %0d want none", cyc);
                end else begin
                    expv = {3'(exp_rd.pop_front()), 3'(exp_rdb.pop_front()),
                            11'(exp_ang.pop_front()), 4'(exp_stg.pop_front())};
                    act  = {if0.rd_ptr, if0.rd_ptr_b, if0.rd_ptr_angle, if0.stage};
                    if (act !== expv) begin
                        bad++; $display("FAIL butterfly inv=%0d cyc=%0d: got rd=%0d b=%0d ang=%0d stg=%0d want rd=%0d b=%0d ang=%0d stg=%0d",
                            inv, cyc, act[20:18], act[17:15], act[14:4], act[3:0],
                            expv[20:18], expv[17:15], expv[14:4], expv[3:0]);
                    end
                end
            end else begin
                total++; if (if0.stage !== 4'd0) begin bad++; $display("FAIL stage_idle cyc=%0d: got %0d want 0", cyc, if0.stage); end
            end
            if (if0.en_rd === 1'b1 && if0.out_valid === 1'b1) begin
                total++; bad++; $display("FAIL strobe_overlap cyc=%0d: got both high want exclusive", cyc);
            end
            if (if0.finish_FFT === 1'b1) begin
                nfin++;
                total++; if (cyc - first_rd != 18) begin bad++; $display("FAIL finish_latency: got %0d want 18", cyc - first_rd); end
            end
            if (if0.out_valid === 1'b1) begin
                total++;
                if (exp_out.size() == 0) begin
                    bad++; $display("FAIL extra_word: got out_ptr=%0d want none", if0.out_ptr);
                end else begin
                    int e;
                    e = exp_out.pop_front();
                    if (if0.out_ptr !== 3'(e)) begin bad++; $display("FAIL out_ptr: got %0d want %0d", if0.out_ptr, e); end
                end
                if (last_out >= 0) begin
                    total++; if (cyc != last_out + 1) begin bad++; $display("FAIL out_consecutive: got gap %0d want 1", cyc - last_out); end
                end
                last_out = cyc;
            end
            if (if0.done_o === 1'b1) begin
                ndone++;
                total++; if (cyc != last_out + 1) begin bad++; $display("FAIL done_timing: got cyc %0d want %0d", cyc, last_out + 1); end
                seen_done = 1;
            end
            @(negedge clk);
        end
        if0.en_out = 1'b0;
        total++; if (!finished) begin bad++; $display("FAIL compute_timeout: got no completion want done_o"); end
        total++; if (exp_rd.size() != 0 || exp_out.size() != 0) begin
            bad++; $display("FAIL leftover: got %0d rd %0d out pending want 0", exp_rd.size(), exp_out.size()); end
        total++; if (nfin != 1 || ndone != 1) begin bad++; $display("FAIL pulse_count: got fin=%0d done=%0d want 1/1", nfin, ndone); end
    endtask

    task automatic test_out_gap();
        int last_out, ndone, nwords, after_done;
        bit prev_en;
        exp_out.delete();
        push_output();
        last_out = -100; ndone = 0; nwords = 0; after_done = -1; prev_en = 0;
        @(negedge clk); if1.start = 1'b1; if1.ifft = 1'b0;
        @(negedge clk); if1.start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (if1.out_valid === 1'b1) begin
                nwords++;
                total++;
                if (exp_out.size() == 0) begin
                    bad++; $display("FAIL gap_extra_word: got out_ptr=%0d want none", if1.out_ptr);
                end else begin
                    int e;
                    e = exp_out.pop_front();
                    if (if1.out_ptr !== 3'(e)) begin bad++; $display("FAIL gap_out_ptr: got %0d want %0d", if1.out_ptr, e); end
                end
                total++; if (cyc - last_out < 4) begin bad++; $display("FAIL out_gap: got spacing %0d want >=4", cyc - last_out); end
                total++; if (!prev_en) begin bad++; $display("FAIL word_without_en_out: got out_valid want stall"); end
                last_out = cyc;
            end
            if (if1.done_o === 1'b1) begin
                ndone++;
                if (after_done < 0) after_done = cyc;
            end
            if (after_done >= 0 && cyc >= after_done + 5) break;
            prev_en = 1'(($urandom_range(0, 2) != 0) ? 1 : 0);
            if1.en_out = prev_en;
            @(negedge clk);
        end
        if1.en_out = 1'b0;
        total++; if (nwords != NW || exp_out.size() != 0) begin bad++; $display("FAIL gap_word_count: got %0d want %0d", nwords, NW); end
        total++; if (ndone != 1) begin bad++; $display("FAIL gap_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_abort();
        int nfin, ndone, fin_cyc;
        bit found;
        found = 0; nfin = 0; ndone = 0; fin_cyc = -1;
        @(negedge clk); if0.start = 1'b1; if0.ifft = 1'b0;
        @(negedge clk); if0.start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (if0.stage === 4'd2) begin found = 1; break; end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL abort_reach_stage2: got no stage 2 want stage 2"); end
        if0.abort = 1'b1; if0.start = 1'b1;
        @(negedge clk);
        total++; if ({if0.busy, if0.en_rd, if0.finish_FFT} !== 3'b000) begin
            bad++; $display("FAIL abort_idle: got busy/en_rd/fin=%b want 000", {if0.busy, if0.en_rd, if0.finish_FFT}); end
        if0.abort = 1'b0;
        @(negedge clk); if0.start = 1'b0;
        total++; if ({if0.en_rd, if0.stage, if0.rd_ptr, if0.rd_ptr_b} !== {1'b1, 4'd1, 3'd0, 3'd1}) begin
            bad++; $display("FAIL restart: got en_rd=%b stage=%0d rd=%0d b=%0d want 1 1 0 1",
                            if0.en_rd, if0.stage, if0.rd_ptr, if0.rd_ptr_b); end
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (if0.finish_FFT === 1'b1) begin nfin++; fin_cyc = cyc; end
            if (if0.done_o === 1'b1) ndone++;
            if (fin_cyc >= 0 && cyc == fin_cyc + 3) if0.abort = 1'b1;
            if (fin_cyc >= 0 && cyc == fin_cyc + 4) if0.abort = 1'b0;
            if (fin_cyc >= 0 && cyc >= fin_cyc + 14) break;
            @(negedge clk);
        end
        if0.abort = 1'b0;
        total++; if (fin_cyc != 18) begin bad++; $display("FAIL restart_finish: got cycle %0d want 18", fin_cyc); end
        total++; if (nfin != 1 || ndone != 0) begin bad++; $display("FAIL abort_pulses: got fin=%0d done=%0d want 1/0", nfin, ndone); end
        total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL abort_output_busy: got %b want 0", if0.busy); end
    endtask

    task automatic test_reset_mid_output();
        int nwords, nbad;
        logic [28:0] v0;
        nwords = 0; nbad = 0;
        @(negedge clk); if0.start = 1'b1; if0.en_out = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        for (int i = 0; i < 80 && nwords < 3; i++) begin
            if (if0.out_valid === 1'b1) nwords++;
            if (nwords < 3) @(negedge clk);
        end
        total++; if (nwords != 3) begin bad++; $display("FAIL reach_output: got %0d words want 3", nwords); end
        #2 rst_n = 1'b0;
        #1;
        v0 = {if0.rd_ptr, if0.rd_ptr_b, if0.rd_ptr_angle, if0.stage, if0.en_rd, if0.out_ptr,
              if0.out_valid, if0.finish_FFT, if0.done_o, if0.busy};
        total++; if (v0 !== 29'd0) begin bad++; $display("FAIL reset_mid_output: got %h want 0", v0); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if0.done_o !== 1'b0 || if0.out_valid !== 1'b0 || if0.busy !== 1'b0) nbad++;
        end
        if0.en_out = 1'b0;
        total++; if (nbad != 0) begin bad++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", nbad); end
    endtask

    task automatic test_back_to_back();
        int nfin, ndone, rd_first, done1, rd_after;
        nfin = 0; ndone = 0; rd_first = 0; done1 = -1; rd_after = -1;
        @(negedge clk); if0.start = 1'b1; if0.en_out = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 150; cyc++) begin
            if (if0.en_rd === 1'b1 && nfin == 0) rd_first++;
            if (if0.en_rd === 1'b1 && done1 >= 0 && rd_after < 0) begin rd_after = cyc; if0.start = 1'b0; end
            if (if0.finish_FFT === 1'b1) nfin++;
            if (if0.done_o === 1'b1) begin ndone++; if (done1 < 0) done1 = cyc; end
            if (ndone == 2) break;
            @(negedge clk);
        end
        if0.start = 1'b0; if0.en_out = 1'b0;
        total++; if (rd_first != 12) begin bad++; $display("FAIL held_start_reads: got %0d want 12", rd_first); end
        total++; if (rd_after - done1 != 2) begin bad++; $display("FAIL b2b_restart: got %0d want 2", rd_after - done1); end
        total++; if (nfin != 2 || ndone != 2) begin bad++; $display("FAIL b2b_pulses: got fin=%0d done=%0d want 2/2", nfin, ndone); end
    endtask

    initial begin
        if0.start = 1'b0; if0.abort = 1'b0; if0.ifft = 1'b0; if0.en_out = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.ifft = 1'b0; if1.en_out = 1'b0;
        test_reset();
        test_compute(1'b0);
        test_compute(1'b1);
        test_out_gap();
        test_abort();
        test_reset_mid_output();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 4, meaning log2 of FFT length N = 2^SIZE, legal range 2..11.
REQ-002 SHALL have parameter PIPE_GAP, default 2, meaning idle cycles after each stage for butterfly pipeline drain, legal range 0..15.
REQ-003 SHALL have parameter OUT_GAP, default 0, meaning minimum idle cycles between output words, legal range 0..65535.
REQ-004 SHALL have parameter BITREV_OUT, default 1; 1 means the output address is bit-reversed, 0 means natural order.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  begin a transform; sampled only in IDLE.
REQ-008 abort  input  1  cancel the current operation from any state.
REQ-009 ifft  input  1  inverse mode; latched on accepted start.
REQ-010 en_out  input  1  downstream ready for an output word.
REQ-011 rd_ptr  output  SIZE  butterfly top-operand address.
REQ-012 rd_ptr_b  output  SIZE  butterfly bottom-operand address.
REQ-013 rd_ptr_angle  output  11  twiddle ROM index; 2048 entries span one full circle.
REQ-014 stage  output  4  current stage 1..SIZE; 0 outside COMPUTE.
REQ-015 en_rd  output  1  butterfly operand read strobe.
REQ-016 out_ptr  output  SIZE  output-phase read address.
REQ-017 out_valid  output  1  output word strobe.
REQ-018 finish_FFT  output  1  one-cycle pulse: all stages complete.
REQ-019 done_o  output  1  one-cycle pulse: all N words output.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, COMPUTE, GAP, FINISH, OUTPUT, DONE.
REQ-022 IDLE SHALL go to COMPUTE on start=1 and abort=0, with stage=1, butterfly counter k=0 and ifft latched.
REQ-023 en_rd SHALL be high in COMPUTE only, for N/2 consecutive cycles per stage, k = 0..N/2-1.
REQ-024 For stage s with span = 2^(s-1) and j = k mod span: rd_ptr SHALL be (k div span)*2*span + j, and rd_ptr_b SHALL be rd_ptr + span.
REQ-025 rd_ptr_angle SHALL be j << (11-s) when the latched ifft=0, and (2048 - (j << (11-s))) mod 2048 when the latched ifft=1.
REQ-026 After k=N/2-1, COMPUTE SHALL go to GAP for PIPE_GAP cycles, or directly to the next step if PIPE_GAP=0. GAP SHALL then go to COMPUTE with stage+1 and k=0, or to FINISH after stage SIZE.
REQ-027 FINISH SHALL last 1 cycle with finish_FFT=1, then go to OUTPUT with m=0.
REQ-028 finish_FFT SHALL rise exactly SIZE*(N/2+PIPE_GAP) cycles after the first en_rd cycle.
REQ-029 In OUTPUT, a word SHALL issue in any cycle where en_out=1 and the gap counter is 0: out_valid=1 for 1 cycle, out_ptr = bitrev(m) if BITREV_OUT=1, else m; m then increments and the gap counter loads OUT_GAP.
REQ-030 The gap counter SHALL decrement every cycle while nonzero, regardless of en_out.
REQ-031 en_out low SHALL stall OUTPUT indefinitely with no word lost or repeated.
REQ-032 After word N-1, the FSM SHALL go to DONE; DONE SHALL last 1 cycle with done_o=1, then return to IDLE.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 abort=1 SHALL force IDLE on the next edge from any state with no finish_FFT and no done_o. abort SHALL win over a simultaneous start.
REQ-035 en_rd and out_valid SHALL never be high in the same cycle.
REQ-036 Address and angle outputs SHALL be registered; they are don't-care when their strobe is low but SHALL hold their last value.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE and clear all counters, the latched ifft and every output to 0; operation resumes on the first edge after release.
REQ-038 Reset asserted mid-COMPUTE or mid-OUTPUT SHALL produce no finish_FFT or done_o pulse.

Verification
REQ-039 SIZE=3, PIPE_GAP=2, ifft=0, start pulse -> stage1 (rd_ptr,rd_ptr_b) = (0,1),(2,3),(4,5),(6,7), angle 0; stage2 = (0,2),(1,3),(4,6),(5,7), angle 0,512,0,512; stage3 = (0,4),(1,5),(2,6),(3,7), angle 0,256,512,768; finish_FFT 18 cycles after the first en_rd.
REQ-040 Same as REQ-039 with ifft=1 -> stage3 angle 0,1792,1536,1280.
REQ-041 SIZE=3, BITREV_OUT=1, OUT_GAP=0, en_out held 1 -> out_ptr 0,4,2,6,1,5,3,7 on 8 consecutive cycles, then done_o the cycle after.
REQ-042 OUT_GAP=3, en_out toggling randomly -> 8 words, at least 3 idle cycles between words, order preserved, exactly one done_o.
REQ-043 abort during stage 2, then start 1 cycle later -> clean restart at stage 1, k=0; no finish_FFT from the aborted run.
REQ-044 rst_n pulsed low mid-OUTPUT -> all outputs 0 immediately; busy=0; no done_o.
